// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor derivation,
// common to the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int uart_divisor(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

  function automatic int uart_half_divisor(input int clk_rate, input int baud_rate);
    return uart_divisor(clk_rate, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input pin, with a
// configurable reset value so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx_deserialise.sv
// UART receiver: oversampled start/data/stop capture on the system clock,
// valid/ready word output, framing-error and overrun pulses.
module uart_rx_deserialise
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int CLK_RATE  = 12000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int DIVISOR = uart_divisor(CLK_RATE, BAUD_RATE);
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam int IDX_W   = $clog2(DATA_BITS + 1);
  localparam int SIDX_W  = $clog2(STOP_BITS + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(uart_half_divisor(CLK_RATE, BAUD_RATE) - 1);
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic [SIDX_W-1:0] LAST_STOP = SIDX_W'(STOP_BITS - 1);

  logic w_rxs;

  uart_state_t          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [SIDX_W-1:0]    r_stop_idx;
  logic [DATA_BITS-1:0] r_word;
  logic                 r_bad_stop;
  logic                 r_done;
  logic                 r_done_bad;

  logic [DATA_BITS-1:0] r_rx_byte;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rxs)
  );

  // The last stop sample drops straight back to IDLE so a following start
  // edge can be caught half a bit early; completion is handled one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= '0;
      r_word     <= '0;
      r_bad_stop <= 1'b0;
      r_done     <= 1'b0;
      r_done_bad <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_state <= START;
            r_cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (r_cnt == '0) begin
            if (!w_rxs) begin
              r_state   <= DATA;
              r_cnt     <= CNT_FULL;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == '0) begin
            r_word <= {w_rxs, r_word[DATA_BITS-1:1]};
            r_cnt  <= CNT_FULL;
            if (r_bit_idx == LAST_BIT) begin
              r_state    <= STOP;
              r_stop_idx <= '0;
              r_bad_stop <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == '0) begin
            r_bad_stop <= r_bad_stop | ~w_rxs;
            r_cnt      <= CNT_FULL;
            if (r_stop_idx == LAST_STOP) begin
              r_state    <= IDLE;
              r_done     <= 1'b1;
              r_done_bad <= r_bad_stop | ~w_rxs;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A fresh delivery always wins over a same-cycle consume, so rx_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_done && !r_done_bad) begin
        r_rx_byte  <= r_word;
        r_rx_valid <= 1'b1;
        r_overrun  <= r_rx_valid && !rx_ready;
      end else begin
        if (r_done && r_done_bad) begin
          r_frame_err <= 1'b1;
        end
        if (r_rx_valid && rx_ready) begin
          r_rx_valid <= 1'b0;
        end
      end
    end
  end

  assign rx_byte   = r_rx_byte;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserialise.sv
// Scoreboard bench for uart_rx_deserialise at DIVISOR=16: stimulus pushes the
// expected word/error event, an independent monitor pops and compares.
module tb_uart_rx_deserialise;

  localparam int DIV = 16;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  uart_rx_deserialise #(
    .DATA_BITS (8),
    .STOP_BITS (1),
    .CLK_RATE  (16),
    .BAUD_RATE (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serial frame generator, also used as the transmit side for loopback.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    idle(DIV);
    check("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(DIV);
    end
    rx = stop_v;
    idle(DIV);
    rx = 1'b1;
  endtask

  task automatic expect_word(input logic [7:0] b, input logic ovr);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    e.ovr    = ovr;
    q.push_back(e);
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    e.ovr    = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: a delivery is a rising rx_valid, a reload right after a
  // handshake, or an overwrite signalled by overrun.
  initial begin
    logic pv;
    logic pr;
    logic deliv;
    exp_t e;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        deliv = rx_valid && (!pv || (pv && pr) || overrun);
        if (deliv || frame_err) begin
          if (q.size() == 0) begin
            check("unexpected_event", 1'b1, 1'b0);
          end else begin
            e = q.pop_front();
            check("event_kind_ferr", frame_err, e.is_err);
            if (!e.is_err) check("rx_byte", rx_byte, e.data);
            check("overrun", overrun, e.ovr);
            $display("event: ferr=%0b byte=%02h ovr=%0b", frame_err, rx_byte, overrun);
          end
        end else if (overrun) begin
          check("stray_overrun", overrun, 1'b0);
        end
        pv = rx_valid;
        pr = rx_ready;
      end
    end
  end

  initial begin
    logic [7:0] lb [4];
    lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hAA; lb[3] = 8'hFF;

    idle(4);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    idle(4);

    // Clean frame, consumer always ready.
    rx_ready = 1'b1;
    expect_word(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    check("busy_after_frame", busy, 1'b0);
    idle(20);
    check("a5_consumed", rx_valid, 1'b0);

    // Start-bit glitch: rejected at the START sample.
    rx = 1'b0;
    idle(5);
    check("glitch_busy_hi", busy, 1'b1);
    rx = 1'b1;
    idle(10);
    check("glitch_busy_lo", busy, 1'b0);
    idle(20);

    // Bad stop bit.
    expect_ferr();
    send_frame(8'h3C, 1'b0);
    idle(30);
    check("ferr_valid_low", rx_valid, 1'b0);
    check("ferr_byte_kept", rx_byte, 8'hA5);

    // Back-to-back with no consumer.
    rx_ready = 1'b0;
    expect_word(8'h00, 1'b0);
    send_frame(8'h00, 1'b1);
    expect_word(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    check("ovr_valid_held", rx_valid, 1'b1);
    check("ovr_byte", rx_byte, 8'hFF);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    idle(1);
    check("handshake_clears", rx_valid, 1'b0);

    // Reset during data bit 4 of 0x5A.
    rx_ready = 1'b1;
    rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = lb[2][0] ^ 1'b0 ? 1'b0 : 1'b0;
      rx = (8'h5A >> i) & 8'h01 ? 1'b1 : 1'b0;
      idle(DIV);
    end
    rx = 1'b1;
    idle(8);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_byte", rx_byte, 8'h00);
    idle(40);
    expect_word(8'h81, 1'b0);
    send_frame(8'h81, 1'b1);
    idle(20);

    // Loopback of four consecutive frames.
    for (int i = 0; i < 4; i++) expect_word(lb[i], 1'b0);
    for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b1);
    idle(20);

    for (int i = 0; i < 300 && q.size() != 0; i++) idle(1);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserialise.md
Name: uart_rx_deserialise

Overview:
UART receiver and the receive-side counterpart of uart_tx_serialise: same frame format (1 start, DATA_BITS data LSB-first, STOP_BITS stop, no parity).
Runs entirely on the system clock. Oversamples the line with an internal baud counter; no derived clock.
Presents each received word on a valid/ready output interface and flags framing and overrun errors.
Sits between the board RX pin and the command/sample FIFO.

Parameters:
DATA_BITS, 8, data bits per frame
STOP_BITS, 1, stop bits checked per frame (1 or 2)
CLK_RATE, 12000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in baud; DIVISOR = CLK_RATE/BAUD_RATE (integer, must be >= 4)

Ports:
clk  input  1  system clock; all logic on posedge clk
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
rx_byte  output  DATA_BITS  received word; stable while rx_valid=1
rx_valid  output  1  word available
rx_ready  input  1  consumer accepts word when rx_valid && rx_ready
busy  output  1  high while state != IDLE
frame_err  output  1  one-cycle pulse: a stop-bit sample was 0
overrun  output  1  one-cycle pulse: a new word overwrote an unconsumed one

Behaviour:
- Reset values: sync flops 1, state IDLE, rx_byte 0, rx_valid 0, frame_err 0, overrun 0, busy 0, counters 0.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs. This adds 2 cycles of latency.
- Baud counter counts down. The sample point is the cycle the counter equals 0.
- IDLE: when rxs==0, go to START and load the counter with DIVISOR/2-1.
- START: at the sample point, if rxs==0, go to DATA, load the counter with DIVISOR-1 and clear the bit index. If rxs==1, the start bit is rejected as a glitch: return to IDLE with no output and no error.
- DATA: at each sample point, shift right with rxs into the MSB, so the word ends LSB-first aligned. Reload DIVISOR-1. After DATA_BITS samples go to STOP and clear the stop index.
- STOP: sample STOP_BITS times, DIVISOR apart. Any 0 sample sets a sticky bad_stop flag. At the last stop sample, return to IDLE in the same cycle, so the receiver can resync half a bit early.
- Completion, on the cycle after the last stop sample:
  - If bad_stop is set: pulse frame_err, discard the word, leave rx_valid unchanged.
  - Otherwise: rx_byte <= word and rx_valid <= 1.
  - If rx_valid was already 1 and not handshaken that cycle, also pulse overrun. The new word replaces the old one.
- Handshake: rx_valid falls on the cycle after rx_valid && rx_ready.
  - Simultaneous consume and delivery: the old word is consumed, the new word loads, rx_valid stays 1, no overrun.
  - rx_ready while rx_valid=0 is ignored.
- Latency: line falling edge to rx_valid is 2 + DIVISOR/2 + (DATA_BITS+STOP_BITS)*DIVISOR + 1 cycles, within ±1 cycle for start-edge detection.
- Line held low (break): START passes, data samples 0, stop sample 0, so frame_err fires. Then IDLE immediately sees rxs==0 and restarts. This is acceptable and must not hang.
- rst mid-frame: the next cycle is fully at reset values, and the partial word is discarded.
- Width rules: the baud counter is $clog2(DIVISOR) bits. The bit index is $clog2(DATA_BITS+1) bits. No counter wraps: every reload is explicit.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, STOP);
  - the DIVISOR/half-DIVISOR derivation, reused by TX and RX.
- One natural sub-module: sync_2ff, a 2-flop synchroniser with a reset value parameter (1 here). Reusable for other async pins.
- Everything else stays inline in one FSM always block plus output registers.

Test Plan:
All scenarios use CLK_RATE=16, BAUD_RATE=1 (DIVISOR=16).
- Frame 0xA5 (stop=1), rx_ready=1 -> rx_valid pulses for exactly 1 cycle with rx_byte=0xA5; frame_err=0 and overrun=0 throughout; busy high from about 2 cycles after the start edge until the mid-stop sample.
- Glitch: rx low for 5 cycles, then high -> no rx_valid, no frame_err; busy drops back at the START sample.
- Frame 0x3C with stop bit driven 0 -> frame_err pulses 1 cycle; rx_valid stays 0 and rx_byte stays at its prior value.
- Back-to-back 0x00 then 0xFF with rx_ready=0 -> overrun pulses at the second completion; rx_byte=0xFF, rx_valid=1. Then rx_ready=1 for 1 cycle -> rx_valid=0.
- Assert rst for 1 cycle mid-data-bit 4 of 0x5A, then send 0x81 -> no output from the aborted frame; clean 0x81 received.
- Loopback from uart_tx_serialise (same parameters): send 0x00, 0x55, 0xAA, 0xFF consecutively -> all four received in order with no errors.
